// File: rtl/data_memory_access_ctrl.sv
// data_memory_access_ctrl
// Initiator side of the SIMPLE data-RAM port. Accepts one load/store/no-op
// request at a time, drives the single-port synchronous RAM through registered
// address/data/write-enable, and returns a one-cycle completion pulse.
// Loads take an extra cycle because the RAM output is only valid the cycle
// after it samples the address.
module data_memory_access_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  reqValid,
    input  logic [1:0]            reqOpcode,
    input  logic [ADDR_WIDTH-1:0] reqAddress,
    input  logic [DATA_WIDTH-1:0] reqWriteData,
    output logic                  reqReady,
    output logic                  respValid,
    output logic [DATA_WIDTH-1:0] respReadData,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic [DATA_WIDTH-1:0] ramData,
    output logic                  ramWren,
    input  logic [DATA_WIDTH-1:0] ramQ
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOAD_ISSUE = 2'b01,
        LOAD_WAIT  = 2'b10,
        STORE      = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    resp_valid_r;
    logic                    resp_valid_next_s;
    logic [DATA_WIDTH-1:0]   resp_read_data_r;
    logic [DATA_WIDTH-1:0]   resp_read_data_next_s;
    logic [ADDR_WIDTH-1:0]   ram_address_r;
    logic [ADDR_WIDTH-1:0]   ram_address_next_s;
    logic [DATA_WIDTH-1:0]   ram_data_r;
    logic [DATA_WIDTH-1:0]   ram_data_next_s;
    logic                    ram_wren_r;
    logic                    ram_wren_next_s;

    // Next-state and next-output decode; pulses default low, data registers hold.
    always_comb begin
        state_next_s          = state_r;
        resp_valid_next_s     = 1'b0;
        ram_wren_next_s       = 1'b0;
        resp_read_data_next_s = resp_read_data_r;
        ram_address_next_s    = ram_address_r;
        ram_data_next_s       = ram_data_r;
        case (state_r)
            IDLE: begin
                if (reqValid) begin
                    case (reqOpcode)
                        OP_LOAD: begin
                            ram_address_next_s = reqAddress;
                            state_next_s       = LOAD_ISSUE;
                        end
                        OP_STORE: begin
                            ram_address_next_s = reqAddress;
                            ram_data_next_s    = reqWriteData;
                            ram_wren_next_s    = 1'b1;
                            state_next_s       = STORE;
                        end
                        default: begin
                            // No-op: complete immediately without touching the RAM.
                            resp_valid_next_s = 1'b1;
                            state_next_s      = IDLE;
                        end
                    endcase
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD_ISSUE: begin
                // RAM samples ram_address at the end of this cycle.
                state_next_s = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                resp_read_data_next_s = ramQ;
                resp_valid_next_s     = 1'b1;
                state_next_s          = IDLE;
            end
            STORE: begin
                // RAM writes at the end of this cycle; wren falls by default.
                resp_valid_next_s = 1'b1;
                state_next_s      = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and output registers; async reset clears everything, which also
    // kills an in-flight store write before its write edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= IDLE;
            resp_valid_r     <= 1'b0;
            resp_read_data_r <= {DATA_WIDTH{1'b0}};
            ram_address_r    <= {ADDR_WIDTH{1'b0}};
            ram_data_r       <= {DATA_WIDTH{1'b0}};
            ram_wren_r       <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            resp_valid_r     <= resp_valid_next_s;
            resp_read_data_r <= resp_read_data_next_s;
            ram_address_r    <= ram_address_next_s;
            ram_data_r       <= ram_data_next_s;
            ram_wren_r       <= ram_wren_next_s;
        end
    end

    assign reqReady     = (state_r == IDLE);
    assign respValid    = resp_valid_r;
    assign respReadData = resp_read_data_r;
    assign ramAddress   = ram_address_r;
    assign ramData      = ram_data_r;
    assign ramWren      = ram_wren_r;

endmodule

// File: tb/tb_data_memory_access_ctrl.sv
// Testbench for data_memory_access_ctrl: a behavioural synchronous RAM is
// attached to the RAM port, and every request is checked against a
// transaction-level model (expected memory contents, last loaded word and
// per-opcode completion latency).
module tb_data_memory_access_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam logic [1:0] OP_NOP0  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_NOP3  = 2'b11;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          reqValid = 1'b0;
    logic [1:0]    reqOpcode = 2'b00;
    logic [AW-1:0] reqAddress = '0;
    logic [DW-1:0] reqWriteData = '0;
    logic          reqReady;
    logic          respValid;
    logic [DW-1:0] respReadData;
    logic [AW-1:0] ramAddress;
    logic [DW-1:0] ramData;
    logic          ramWren;
    logic [DW-1:0] ramQ = '0;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int exp_wren = 0;
    int wren_cycles = 0;
    int resp_pulses = 0;
    int mem_seed = 0;
    logic ram_init = 1'b1;

    logic [DW-1:0] ram_mem [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] exp_rd = '0;

    always #5 clock = ~clock;

    data_memory_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .reqValid     (reqValid),
        .reqOpcode    (reqOpcode),
        .reqAddress   (reqAddress),
        .reqWriteData (reqWriteData),
        .reqReady     (reqReady),
        .respValid    (respValid),
        .respReadData (respReadData),
        .ramAddress   (ramAddress),
        .ramData      (ramData),
        .ramWren      (ramWren),
        .ramQ         (ramQ)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i * 40503 + mem_seed);
    endfunction

    // Completion latency in falling edges after the accepting rising edge.
    function automatic int exp_lat(input logic [1:0] op);
        if (op == OP_LOAD) return 3;
        if (op == OP_STORE) return 2;
        return 1;
    endfunction

    // Single-port synchronous RAM: write on wren, registered read output.
    always @(posedge clock) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
        end else begin
            if (ramWren) ram_mem[ramAddress] <= ramData;
            ramQ <= ram_mem[ramAddress];
        end
    end

    // Counts write-enable cycles and completion pulses outside reset.
    always @(negedge clock) begin
        if (reset_n && ramWren) wren_cycles <= wren_cycles + 1;
        if (reset_n && respValid) resp_pulses <= resp_pulses + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request starting at a falling edge; returns at the falling
    // edge where the completion pulse is seen, with reqValid dropped.
    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit hold);
        int  waited;
        int  lat;
        bit  acc;
        reqValid = 1'b1;
        reqOpcode = op;
        reqAddress = addr;
        reqWriteData = wdata;
        waited = 0;
        acc = 1'b0;
        while (!acc && waited < 8) begin
            acc = reqReady;
            @(negedge clock);
            waited++;
        end
        if (!acc) begin
            check_val("accept_timeout", 32'(waited), 32'd1);
            reqValid = 1'b0;
            return;
        end
        // Scramble request fields; they must be ignored while busy.
        if (op == OP_LOAD || op == OP_STORE) begin
            reqValid = hold;
            reqOpcode = 2'($urandom_range(0, 3));
            reqAddress = AW'($urandom_range(0, 255));
            reqWriteData = DW'($urandom_range(0, 65535));
        end
        if (op == OP_STORE) begin
            check_val("store_wren", 32'(ramWren), 32'd1);
            check_val("store_addr", 32'(ramAddress), 32'(addr));
            check_val("store_data", 32'(ramData), 32'(wdata));
            exp_wren++;
        end
        lat = 1;
        while (!respValid && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        reqValid = 1'b0;
        check_val("resp_latency", 32'(lat), 32'(exp_lat(op)));
        if (op == OP_LOAD) exp_rd = ref_mem[addr];
        if (op == OP_STORE) ref_mem[addr] = wdata;
        check_val("resp_data", 32'(respReadData), 32'(exp_rd));
        check_val("ready_at_resp", 32'(reqReady), 32'd1);
        check_val("wren_at_resp", 32'(ramWren), 32'd0);
        n_done++;
    endtask

    task automatic idle_gap(input int n);
        reqValid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check_val("idle_no_resp", 32'(respValid), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(reqReady), 32'd1);
        check_val({tag, "_respvalid"}, 32'(respValid), 32'd0);
        check_val({tag, "_wren"}, 32'(ramWren), 32'd0);
        check_val({tag, "_addr"}, 32'(ramAddress), 32'd0);
        check_val({tag, "_data"}, 32'(ramData), 32'd0);
        check_val({tag, "_rdata"}, 32'(respReadData), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] a;
        bit            hold;
        mem_seed = int'($urandom_range(0, 65535));
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset_n = 1'b0;
        ram_init = 1'b1;
        repeat (2) @(negedge clock);
        ram_init = 1'b0;
        check_reset_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_reset_outputs("post_reset");

        // Directed store then load of the same word.
        do_req(OP_STORE, 8'h12, 16'hBEEF, 1'b0);
        do_req(OP_LOAD, 8'h12, 16'h0000, 1'b0);
        check_val("load_beef", 32'(respReadData), 32'h0000BEEF);
        do_req(OP_STORE, 8'h34, 16'h1111, 1'b0);
        do_req(OP_NOP0, 8'h12, 16'h2222, 1'b0);
        do_req(OP_NOP3, 8'h56, 16'h3333, 1'b0);
        check_val("beef_held", 32'(respReadData), 32'h0000BEEF);
        idle_gap(2);

        // reqValid held high with alternating store/load at both address extremes.
        for (int i = 0; i < 8; i++) begin
            a = (i % 2 == 1) ? 8'hFF : 8'h00;
            do_req(OP_STORE, a, DW'($urandom_range(0, 65535)), 1'b1);
            do_req(OP_LOAD, a, DW'($urandom_range(0, 65535)), 1'b1);
        end
        idle_gap(1);

        // Reset during STORE, before the write edge.
        reqValid = 1'b1; reqOpcode = OP_STORE; reqAddress = 8'h12; reqWriteData = 16'h1234;
        @(negedge clock);
        reqValid = 1'b0;
        check_val("abort_store_wren", 32'(ramWren), 32'd1);
        exp_wren++;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("abort_store");
        exp_rd = '0;
        @(negedge clock);
        check_val("abort_store_no_resp", 32'(respValid), 32'd0);
        reset_n = 1'b1;
        do_req(OP_LOAD, 8'h12, 16'h0000, 1'b0);
        check_val("abort_store_kept", 32'(respReadData), 32'h0000BEEF);

        // Reset during LOAD_WAIT.
        reqValid = 1'b1; reqOpcode = OP_LOAD; reqAddress = 8'h34; reqWriteData = 16'h0;
        @(negedge clock);
        reqValid = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("abort_load");
        exp_rd = '0;
        @(negedge clock);
        check_val("abort_load_no_resp", 32'(respValid), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_val("abort_load_no_resp2", 32'(respValid), 32'd0);
        check_val("abort_load_rdata", 32'(respReadData), 32'd0);
        do_req(OP_LOAD, 8'h34, 16'h0000, 1'b0);
        check_val("after_abort_load", 32'(respReadData), 32'h00001111);

        // Randomized traffic, biased towards a few addresses for aliasing.
        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 255));
            hold = ($urandom_range(0, 1) == 1);
            do_req(op, a, DW'($urandom_range(0, 65535)), hold);
            if (!hold) idle_gap(int'($urandom_range(0, 2)));
        end
        idle_gap(2);

        check_val("wren_cycle_count", 32'(wren_cycles), 32'(exp_wren));
        check_val("resp_pulse_count", 32'(resp_pulses), 32'(n_done));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
